// File: rtl/sort_pkg.sv
// ---------------------------------------------------------------------------
// sort_pkg
// Shared definitions for the quicksort result streamer:
//   - ELEM_W_DEF   : default element width
//   - stream_state_e : streamer FSM state encoding
//   - idx_width()  : index width for an array of n elements (at least 1 bit)
// ---------------------------------------------------------------------------
package sort_pkg;

  localparam int ELEM_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_STREAM   = 2'd1,
    ST_WAIT_LOW = 2'd2
  } stream_state_e;

  // A single-element array still needs a 1-bit index port.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sort_result_streamer_if.sv
// ---------------------------------------------------------------------------
// sort_result_streamer_if
// Valid/ready element stream carrying the sorted result.
//   m_data  : current element
//   m_index : index of m_data within the array
//   m_valid : beat valid
//   m_ready : consumer accepts the beat when m_valid && m_ready
//   m_last  : final element of the array
// Modports: master (streamer side), slave (consumer side).
// ---------------------------------------------------------------------------
interface sort_result_streamer_if
  import sort_pkg::*;
#(
  parameter int ELEM_W = ELEM_W_DEF,
  parameter int IDX_W  = 1
);

  logic [ELEM_W-1:0] m_data;
  logic [IDX_W-1:0]  m_index;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;

  modport master (output m_data, m_index, m_valid, m_last, input m_ready);
  modport slave  (input m_data, m_index, m_valid, m_last, output m_ready);

endinterface

// File: rtl/sort_result_streamer.sv
// ---------------------------------------------------------------------------
// sort_result_streamer
// Snapshots the packed sorted array when array_valid is high and serialises
// it, lowest index first, onto a valid/ready element stream. The snapshot lets
// the sorter restart while the result is still draining.
//
// Ports:
//   clock       : sole clock, rising edge
//   reset_n     : asynchronous active-low reset
//   array_in    : packed sorted array, element i = [i*ELEM_W +: ELEM_W]
//   array_valid : level, array_in holds a complete result
//   array_ack   : one-cycle pulse on the cycle after capture
//   m           : element stream (master modport)
//   busy        : high whenever the FSM is not idle
//   order_err   : sticky descending-pair flag (only with SORT_CHECK_EN)
//
// Build option: define SORT_CHECK_EN to build the ascending-order checker;
// otherwise order_err is tied low.
// ---------------------------------------------------------------------------
module sort_result_streamer
  import sort_pkg::*;
#(
  parameter int ARR_WIDTH = 4,
  parameter int ELEM_W    = ELEM_W_DEF
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [ARR_WIDTH*ELEM_W-1:0] array_in,
  input  logic                        array_valid,
  output logic                        array_ack,
  sort_result_streamer_if.master      m,
  output logic                        busy,
  output logic                        order_err
);

  localparam int              IDX_W    = idx_width(ARR_WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ARR_WIDTH - 1);

  stream_state_e                    state_q, state_d;
  logic [IDX_W-1:0]                 idx_q, idx_d;
  logic                             ack_q, ack_d;
  logic                             capture;
  logic [ARR_WIDTH-1:0][ELEM_W-1:0] snap_q;
  logic [ELEM_W-1:0]                cur_elem;

  assign cur_elem = snap_q[idx_q];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ack_d   = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (array_valid) begin
          capture = 1'b1;
          ack_d   = 1'b1;
          idx_d   = '0;
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (m.m_ready) begin
          if (idx_q == LAST_IDX) state_d = ST_WAIT_LOW;
          else                   idx_d   = idx_q + 1'b1;
        end
      end
      // Wait for the level to drop so one result is never streamed twice.
      ST_WAIT_LOW: begin
        if (!array_valid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      ack_q   <= 1'b0;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ack_q   <= ack_d;
      if (capture) snap_q <= array_in;
    end
  end

  // Outputs decode only registered state, so nothing from m_ready or
  // array_valid reaches them combinationally.
  assign m.m_valid = (state_q == ST_STREAM);
  assign m.m_data  = cur_elem;
  assign m.m_index = idx_q;
  assign m.m_last  = (state_q == ST_STREAM) && (idx_q == LAST_IDX);
  assign busy      = (state_q != ST_IDLE);
  assign array_ack = ack_q;

`ifdef SORT_CHECK_EN
  logic              beat;
  logic [ELEM_W-1:0] prev_q;
  logic              err_q;

  assign beat = (state_q == ST_STREAM) && m.m_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prev_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (capture) begin
        err_q <= 1'b0;
      end else if (beat && (idx_q != '0) && (cur_elem < prev_q)) begin
        err_q <= 1'b1;
      end
      if (beat) prev_q <= cur_elem;
    end
  end

  assign order_err = err_q;
`else
  assign order_err = 1'b0;
`endif

endmodule

// File: tb/tb_sort_result_streamer.sv
module tb_sort_result_streamer;

  localparam int AW = 4;
  localparam int EW = 4;
  localparam int IW = 2;

`ifdef SORT_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [AW*EW-1:0] array_in = '0;
  logic          array_valid = 1'b0;
  logic          array_ack;
  logic          busy;
  logic          order_err;

  sort_result_streamer_if #(.ELEM_W(EW), .IDX_W(IW)) sif ();

  sort_result_streamer #(.ARR_WIDTH(AW), .ELEM_W(EW)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .array_in    (array_in),
    .array_valid (array_valid),
    .array_ack   (array_ack),
    .m           (sif),
    .busy        (busy),
    .order_err   (order_err)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Observations gathered by run_stream
  logic [EW-1:0] got_d[$];
  int            got_i[$];
  bit            got_l[$];
  bit            got_e[$];
  int            acks;
  int            stall_bad;
  int            iters;
  bit            timed_out;
  bit [6:0]      rpat = 7'b1011001;   // ready sequence 1,0,0,1,1,0,1

  // Reference model: element i of a packed array, and whether the array
  // contains any descending neighbour pair.
  function automatic logic [EW-1:0] elem(input logic [AW*EW-1:0] a, input int i);
    return a[i*EW +: EW];
  endfunction

  function automatic bit has_descent(input logic [AW*EW-1:0] a);
    for (int i = 1; i < AW; i++)
      if (elem(a, i) < elem(a, i-1)) return 1'b1;
    return 1'b0;
  endfunction

  // Drives m_ready per cycle and records every accepted beat until m_last.
  // mode 0: always ready, 1: fixed pattern, 2: random.
  task automatic run_stream(input int mode, input bit corrupt);
    bit done = 0;
    bit stalled = 0;
    logic [EW-1:0] pd = '0;
    logic [IW-1:0] pi = '0;
    logic pl = 1'b0;
    got_d.delete(); got_i.delete(); got_l.delete(); got_e.delete();
    acks = 0; stall_bad = 0; iters = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clock);
      iters++;
      if (corrupt && c == 1) array_in = '1;
      case (mode)
        0:       sif.m_ready = 1'b1;
        1:       sif.m_ready = rpat[c % 7];
        default: sif.m_ready = 1'($urandom_range(0, 1));
      endcase
      if (array_ack) acks++;
      got_e.push_back(order_err);
      if (stalled && (!sif.m_valid || sif.m_data !== pd || sif.m_index !== pi || sif.m_last !== pl))
        stall_bad++;
      if (sif.m_valid && sif.m_ready) begin
        got_d.push_back(sif.m_data);
        got_i.push_back(int'(sif.m_index));
        got_l.push_back(sif.m_last);
        $display("beat idx=%0d data=%h last=%0b", sif.m_index, sif.m_data, sif.m_last);
        if (sif.m_last) done = 1;
      end
      stalled = sif.m_valid && !sif.m_ready;
      pd = sif.m_data; pi = sif.m_index; pl = sif.m_last;
    end
    timed_out = !done;
  endtask

  task automatic drop_valid();
    @(negedge clock);
    array_valid = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_reset();
    sif.m_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    total++; if (sif.m_valid !== 1'b0) begin bad++; $display("FAIL reset_m_valid got=%b want=0", sif.m_valid); end
    total++; if (array_ack !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b want=0", array_ack); end
    total++; if (busy !== 1'b0 || order_err !== 1'b0) begin bad++; $display("FAIL reset_busy_err got=%b%b want=00", busy, order_err); end
    total++; if (sif.m_data !== '0 || sif.m_index !== '0 || sif.m_last !== 1'b0) begin
      bad++; $display("FAIL reset_data got=%h/%0d/%b want=0/0/0", sif.m_data, sif.m_index, sif.m_last);
    end
    @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    total++; if (busy !== 1'b0 || sif.m_valid !== 1'b0) begin bad++; $display("FAIL post_reset_idle busy=%b valid=%b want=0/0", busy, sif.m_valid); end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    logic [AW*EW-1:0] arr = 16'h9731;
    array_in = arr; array_valid = 1'b1; sif.m_ready = 1'b1;
    run_stream(0, 0);
    total++; if (acks !== 1) begin bad++; $display("FAIL basic_acks got=%0d want=1", acks); end
    total++; if (got_d.size() !== AW || iters !== AW) begin
      bad++; $display("FAIL basic_count beats=%0d cycles=%0d want=%0d/%0d", got_d.size(), iters, AW, AW);
    end
    for (int i = 0; i < got_d.size() && i < AW; i++) begin
      total++;
      if (got_d[i] !== elem(arr, i) || got_i[i] !== i || got_l[i] !== (i == AW-1)) begin
        bad++; $display("FAIL basic_beat%0d got=%h/%0d/%b want=%h/%0d/%b", i, got_d[i], got_i[i], got_l[i], elem(arr, i), i, i == AW-1);
      end
    end
    @(negedge clock);
    total++; if (sif.m_valid !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL basic_after_last valid=%b busy=%b want=0/1", sif.m_valid, busy); end
    drop_valid();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_idle busy=%b want=0", busy); end
  endtask

  task automatic test_backpressure();
    logic [AW*EW-1:0] arr = 16'h9731;
    array_in = arr; array_valid = 1'b1;
    run_stream(1, 0);
    total++; if (stall_bad !== 0) begin bad++; $display("FAIL bp_stall_stable changes=%0d want=0", stall_bad); end
    total++; if (got_d.size() !== AW) begin bad++; $display("FAIL bp_count got=%0d want=%0d", got_d.size(), AW); end
    for (int i = 0; i < got_d.size() && i < AW; i++) begin
      total++;
      if (got_d[i] !== elem(arr, i) || got_i[i] !== i || got_l[i] !== (i == AW-1)) begin
        bad++; $display("FAIL bp_beat%0d got=%h/%0d/%b want=%h/%0d/%b", i, got_d[i], got_i[i], got_l[i], elem(arr, i), i, i == AW-1);
      end
    end
    drop_valid();
  endtask

  task automatic test_level_rearm();
    logic [AW*EW-1:0] arr = 16'h9731;
    int extra_ack = 0;
    int extra_valid = 0;
    array_in = arr; array_valid = 1'b1; sif.m_ready = 1'b1;
    run_stream(0, 0);
    repeat (6) begin
      @(negedge clock);
      if (array_ack) extra_ack++;
      if (sif.m_valid) extra_valid++;
    end
    total++; if (extra_ack !== 0 || extra_valid !== 0) begin
      bad++; $display("FAIL rearm_hold acks=%0d valids=%0d want=0/0", extra_ack, extra_valid);
    end
    drop_valid();
    arr = 16'h8642;
    array_in = arr; array_valid = 1'b1;
    run_stream(0, 0);
    total++; if (acks !== 1 || got_d.size() !== AW) begin bad++; $display("FAIL rearm_count acks=%0d beats=%0d want=1/%0d", acks, got_d.size(), AW); end
    for (int i = 0; i < got_d.size() && i < AW; i++) begin
      total++;
      if (got_d[i] !== elem(arr, i) || got_i[i] !== i) begin
        bad++; $display("FAIL rearm_beat%0d got=%h/%0d want=%h/%0d", i, got_d[i], got_i[i], elem(arr, i), i);
      end
    end
    drop_valid();
  endtask

  task automatic test_snapshot();
    logic [AW*EW-1:0] arr = 16'hC852;
    array_in = arr; array_valid = 1'b1; sif.m_ready = 1'b1;
    run_stream(0, 1);
    total++; if (got_d.size() !== AW) begin bad++; $display("FAIL snap_count got=%0d want=%0d", got_d.size(), AW); end
    for (int i = 0; i < got_d.size() && i < AW; i++) begin
      total++;
      if (got_d[i] !== elem(arr, i)) begin
        bad++; $display("FAIL snap_beat%0d got=%h want=%h", i, got_d[i], elem(arr, i));
      end
    end
    drop_valid();
  endtask

  task automatic test_reset_midstream();
    logic [AW*EW-1:0] arr = 16'h9731;
    array_in = arr; array_valid = 1'b1; sif.m_ready = 1'b1;
    repeat (3) @(negedge clock);   // two beats accepted, third on the bus
    total++; if (sif.m_index !== 2'd2) begin bad++; $display("FAIL mid_pre_reset idx=%0d want=2", sif.m_index); end
    reset_n = 1'b0;
    #1;
    total++; if (sif.m_valid !== 1'b0 || busy !== 1'b0 || array_ack !== 1'b0 || order_err !== 1'b0 || sif.m_index !== '0) begin
      bad++; $display("FAIL mid_async_reset valid=%b busy=%b ack=%b err=%b idx=%0d want=0/0/0/0/0", sif.m_valid, busy, array_ack, order_err, sif.m_index);
    end
    array_valid = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_wait_idle busy=%b want=0", busy); end
    arr = 16'hEA40;
    array_in = arr; array_valid = 1'b1;
    run_stream(0, 0);
    total++; if (got_d.size() !== AW) begin bad++; $display("FAIL mid_count got=%0d want=%0d", got_d.size(), AW); end
    for (int i = 0; i < got_d.size() && i < AW; i++) begin
      total++;
      if (got_d[i] !== elem(arr, i) || got_i[i] !== i) begin
        bad++; $display("FAIL mid_beat%0d got=%h/%0d want=%h/%0d", i, got_d[i], got_i[i], elem(arr, i), i);
      end
    end
    drop_valid();
  endtask

  task automatic test_order_check();
    logic [AW*EW-1:0] arr = 16'h2531;
    int early = 0;
    array_in = arr; array_valid = 1'b1; sif.m_ready = 1'b1;
    run_stream(0, 0);
    foreach (got_e[k]) if (got_e[k]) early++;
    total++; if (early !== 0) begin bad++; $display("FAIL order_early got=%0d want=0", early); end
    @(negedge clock);
    total++; if (order_err !== CHK) begin bad++; $display("FAIL order_set got=%b want=%b", order_err, CHK); end
    repeat (3) @(negedge clock);
    total++; if (order_err !== CHK) begin bad++; $display("FAIL order_sticky got=%b want=%b", order_err, CHK); end
    drop_valid();
    total++; if (order_err !== CHK) begin bad++; $display("FAIL order_sticky_idle got=%b want=%b", order_err, CHK); end
    arr = 16'h9731;
    array_in = arr; array_valid = 1'b1;
    run_stream(0, 0);
    total++; if (got_e.size() == 0 || got_e[0] !== 1'b0) begin bad++; $display("FAIL order_clear got=%b want=0", got_e.size() ? got_e[0] : 1'bx); end
    drop_valid();
  endtask

  task automatic test_random();
    for (int t = 0; t < 20; t++) begin
      int v[AW];
      logic [AW*EW-1:0] arr;
      bit want_err;
      for (int i = 0; i < AW; i++) v[i] = $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1)
        for (int i = 0; i < AW-1; i++)
          for (int j = 0; j < AW-1-i; j++)
            if (v[j] > v[j+1]) begin int tmp = v[j]; v[j] = v[j+1]; v[j+1] = tmp; end
      for (int i = 0; i < AW; i++) arr[i*EW +: EW] = EW'(v[i]);
      want_err = CHK & has_descent(arr);
      array_in = arr; array_valid = 1'b1;
      run_stream(2, 0);
      total++; if (got_d.size() !== AW || stall_bad !== 0) begin
        bad++; $display("FAIL rand%0d_count beats=%0d stall_changes=%0d want=%0d/0", t, got_d.size(), stall_bad, AW);
      end
      for (int i = 0; i < got_d.size() && i < AW; i++) begin
        total++;
        if (got_d[i] !== elem(arr, i) || got_i[i] !== i || got_l[i] !== (i == AW-1)) begin
          bad++; $display("FAIL rand%0d_beat%0d got=%h/%0d/%b want=%h/%0d/%b", t, i, got_d[i], got_i[i], got_l[i], elem(arr, i), i, i == AW-1);
        end
      end
      @(negedge clock);
      total++; if (order_err !== want_err) begin bad++; $display("FAIL rand%0d_err got=%b want=%b", t, order_err, want_err); end
      drop_valid();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_level_rearm();
    test_snapshot();
    test_reset_midstream();
    test_order_check();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
